// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the oversampled I2C register target.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - ACK/NACK bus levels
//   - depth of the pad synchroniser chains
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_bus_cond.sv
// ---------------------------------------------------------------------------
// i2c_bus_cond
// Brings the raw SCL/SDA pad inputs into the system clock domain and turns
// them into single-cycle bus events.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   scl_i, sda_i     raw asynchronous pad inputs
//   scl_rise         1-cycle pulse on a synchronised SCL 0->1
//   scl_fall         1-cycle pulse on a synchronised SCL 1->0
//   start            SDA fell while SCL was (and stays) high
//   stop             SDA rose while SCL was (and stays) high
//   sda_s            synchronised SDA level
// ---------------------------------------------------------------------------
module i2c_bus_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Synchroniser chains plus one history stage per line. Reset to the idle
    // bus level (both high) so leaving reset never looks like a START/STOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    // START/STOP require SCL high in both the current and history sample, so
    // an SDA change coinciding with an SCL edge is never taken as a condition.
    assign scl_rise = w_scl & ~r_scl_hist;
    assign scl_fall = ~w_scl & r_scl_hist;
    assign start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
    assign sda_s    = w_sda;

endmodule

// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
// I2C target with a DEPTH-byte register file, running entirely on clk and
// oversampling the bus. Supports pointer writes, burst read/write with
// auto-increment and wrap, repeated START, and a host-side register port.
// Ports:
//   clk, reset            system clock (>= 16x SCL), synchronous active-high
//   scl_i, sda_i          raw pad inputs
//   sda_oe                1 = pull SDA low, 0 = release
//   host_we/addr/wdata    host write port (host loses to a same-cycle I2C write)
//   host_rdata            registered post-write value of regs[host_addr]
//   rx_valid, rx_addr     pulse + address for each I2C-written data byte
//   busy                  address-matched transaction in progress
// ---------------------------------------------------------------------------
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h02,
    parameter int         DEPTH      = 16,
    localparam int        AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          rx_valid,
    output logic [AW-1:0] rx_addr,
    output logic          busy
);

    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic          w_sda_s;

    logic [3:0]    r_state;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_ptr;
    logic          r_rw;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_rx_valid;
    logic [AW-1:0] r_rx_addr;
    logic [7:0]    r_regs [DEPTH];
    logic [7:0]    r_host_rdata;

    logic [7:0]    w_byte;
    logic          w_byte_done;
    logic          w_commit;
    logic [7:0]    w_post;

    i2c_bus_cond u_bus_cond (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start    (w_start),
        .stop     (w_stop),
        .sda_s    (w_sda_s)
    );

    // The byte as it will look once the bit arriving on this SCL rise is
    // shifted in; lets the 8th-bit decisions act in the same cycle.
    assign w_byte      = {r_shift[6:0], w_sda_s};
    assign w_byte_done = w_scl_rise && (r_bitcnt == 4'd7);
    assign w_commit    = (r_state == ST_WDATA) && w_byte_done;

    // Protocol FSM and shifter. bit counter: 0..7 data bits received/sent,
    // 8 = in the ACK slot before its SCL rise, 9 = ACK slot rise seen.
    // STOP outranks START; neither can coincide with an SCL edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'h00;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_addr  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_byte_done) begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_byte_done) begin
                                r_ptr   <= w_byte[AW-1:0];
                                r_state <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_byte_done) begin
                                r_rx_valid <= 1'b1;
                                r_rx_addr  <= r_ptr;
                                r_ptr      <= r_ptr + AW'(1);
                                r_state    <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall && r_bitcnt == 4'd8) begin
                            r_sda_oe <= 1'b1;
                        end else if (w_scl_rise && r_bitcnt == 4'd8) begin
                            r_bitcnt <= 4'd9;
                        end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                            r_bitcnt <= 4'd0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                r_state  <= ST_RDATA;
                                r_shift  <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_byte_done) begin
                                r_ptr   <= r_ptr + AW'(1);
                                r_state <= ST_RDATA_ACK;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_scl_fall && r_bitcnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                        end else if (w_scl_rise && r_bitcnt == 4'd8) begin
                            if (w_sda_s == ACK) begin
                                r_bitcnt <= 4'd9;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                            r_bitcnt <= 4'd0;
                            r_state  <= ST_RDATA;
                            r_shift  <= r_regs[r_ptr];
                            r_sda_oe <= ~r_regs[r_ptr][7];
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Value regs[host_addr] will hold after this cycle's writes, so the host
    // read sees the post-write data. The I2C commit is applied last and wins.
    always_comb begin
        w_post = r_regs[host_addr];
        if (host_we) begin
            w_post = host_wdata;
        end
        if (w_commit && (r_ptr == host_addr)) begin
            w_post = w_byte;
        end
    end

    // Register file and registered host read port. The I2C write follows the
    // host write so it takes precedence on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_host_rdata <= 8'h00;
        end else begin
            if (host_we) begin
                r_regs[host_addr] <= host_wdata;
            end
            if (w_commit) begin
                r_regs[r_ptr] <= w_byte;
            end
            r_host_rdata <= w_post;
        end
    end

    assign sda_oe     = r_sda_oe;
    assign busy       = r_busy;
    assign rx_valid   = r_rx_valid;
    assign rx_addr    = r_rx_addr;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regs
// Bit-banged I2C master driving an open-drain bus model into i2c_slave_regs,
// with host-port vector tables and hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regs;

    localparam int Q = 8;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] expRdata;
    } hostVec_t;

    typedef struct {
        logic [7:0] ptrByte;
        logic [7:0] data;
        logic [3:0] regAddr;
    } i2cVec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclM = 1'b1;
    logic       sdaM = 1'b1;
    logic       hostWe = 1'b0;
    logic [3:0] hostAddr = 4'd0;
    logic [7:0] hostWdata = 8'h00;
    logic [7:0] hostRdata;
    logic       sdaOe;
    logic       rxValid;
    logic [3:0] rxAddr;
    logic       busy;
    logic       sdaLine;

    int nVec = 0;
    int nMiss = 0;
    int oeCount = 0;
    int busyCount = 0;
    logic [3:0] rxLog [$];

    hostVec_t hostVec [9];
    i2cVec_t  i2cVec [4];

    logic       ack;
    logic       ackAny;
    logic       bitv;
    logic [7:0] d;
    int         base;
    int         oe0;
    int         busy0;

    // Open-drain bus: the line is low if either side pulls it low.
    assign sdaLine = sdaM & ~sdaOe;

    always #5 clk = ~clk;

    i2c_slave_regs #(
        .SLAVE_ADDR (7'h02),
        .DEPTH      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (sclM),
        .sda_i      (sdaLine),
        .sda_oe     (sdaOe),
        .host_we    (hostWe),
        .host_addr  (hostAddr),
        .host_wdata (hostWdata),
        .host_rdata (hostRdata),
        .rx_valid   (rxValid),
        .rx_addr    (rxAddr),
        .busy       (busy)
    );

    // Passive monitor: counts SDA-drive and busy cycles, logs committed addresses.
    always @(negedge clk) begin
        if (sdaOe === 1'b1) oeCount++;
        if (busy === 1'b1) busyCount++;
        if (rxValid === 1'b1) rxLog.push_back(rxAddr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitQ(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; waitQ(1);
        sclM = 1'b1; waitQ(1);
        sdaM = 1'b0; waitQ(1);
        sclM = 1'b0; waitQ(1);
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitQ(1);
        sclM = 1'b1; waitQ(1);
        sdaM = 1'b1; waitQ(2);
    endtask

    task automatic writeBit(input logic b);
        sdaM = b;    waitQ(1);
        sclM = 1'b1; waitQ(2);
        sclM = 1'b0; waitQ(1);
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1; waitQ(1);
        sclM = 1'b1; waitQ(1);
        b = sdaLine; waitQ(1);
        sclM = 1'b0; waitQ(1);
    endtask

    task automatic writeByte(input logic [7:0] data, output logic a);
        for (int i = 7; i >= 0; i--) writeBit(data[i]);
        readBit(a);
    endtask

    task automatic readByte(output logic [7:0] data, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            data[i] = b;
        end
        writeBit(mack);
    endtask

    task automatic readReg(input logic [3:0] a, output logic [7:0] data);
        hostWe = 1'b0;
        hostAddr = a;
        @(negedge clk);
        data = hostRdata;
    endtask

    // One host-port vector: drive for a cycle, compare the registered read.
    task automatic applyStimulus(input hostVec_t v, input int idx);
        hostWe = v.we;
        hostAddr = v.addr;
        hostWdata = v.wdata;
        @(negedge clk);
        hostWe = 1'b0;
        checkOutput($sformatf("host vec %0d rdata", idx), hostRdata, v.expRdata);
    endtask

    initial begin
        hostVec[0] = '{1'b1, 4'd1, 8'h12, 8'h12};
        hostVec[1] = '{1'b0, 4'd1, 8'h00, 8'h12};
        hostVec[2] = '{1'b1, 4'd2, 8'h34, 8'h34};
        hostVec[3] = '{1'b0, 4'd1, 8'h00, 8'h12};
        hostVec[4] = '{1'b0, 4'd2, 8'h00, 8'h34};
        hostVec[5] = '{1'b1, 4'd1, 8'hAB, 8'hAB};
        hostVec[6] = '{1'b0, 4'd3, 8'h00, 8'h00};
        hostVec[7] = '{1'b1, 4'd6, 8'hC6, 8'hC6};
        hostVec[8] = '{1'b0, 4'd1, 8'h00, 8'hAB};

        i2cVec[0] = '{8'h03, 8'h3C, 4'd3};
        i2cVec[1] = '{8'h08, 8'h00, 4'd8};
        i2cVec[2] = '{8'h09, 8'hFF, 4'd9};
        i2cVec[3] = '{8'h1A, 8'h81, 4'd10};

        // Reset state
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset sda_oe", sdaOe, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rx_valid", rxValid, 0);
        checkOutput("reset host_rdata", hostRdata, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Host port table
        for (int i = 0; i < 9; i++) applyStimulus(hostVec[i], i);

        // Test 1: pointer 4, write A5, 5A
        base = rxLog.size();
        i2cStart();
        writeByte(8'h04, ack); checkOutput("t1 addr ack", ack, 0);
        checkOutput("t1 busy during", busy, 1);
        writeByte(8'h04, ack); checkOutput("t1 ptr ack", ack, 0);
        writeByte(8'hA5, ack); checkOutput("t1 d0 ack", ack, 0);
        writeByte(8'h5A, ack); checkOutput("t1 d1 ack", ack, 0);
        i2cStop();
        checkOutput("t1 busy after stop", busy, 0);
        checkOutput("t1 rx count", rxLog.size() - base, 2);
        if (rxLog.size() >= base + 2) begin
            checkOutput("t1 rx_addr 0", rxLog[base], 4);
            checkOutput("t1 rx_addr 1", rxLog[base + 1], 5);
        end
        readReg(4'd4, d); checkOutput("t1 regs[4]", d, 8'hA5);
        readReg(4'd5, d); checkOutput("t1 regs[5]", d, 8'h5A);

        // Test 2: pointer 4, repeated START, read two bytes
        i2cStart();
        writeByte(8'h04, ack);
        writeByte(8'h04, ack); checkOutput("t2 ptr ack", ack, 0);
        i2cStart();
        writeByte(8'h05, ack); checkOutput("t2 raddr ack", ack, 0);
        readByte(d, 1'b0); checkOutput("t2 rd0", d, 8'hA5);
        readByte(d, 1'b1); checkOutput("t2 rd1", d, 8'h5A);
        repeat (4) @(negedge clk);
        checkOutput("t2 sda_oe after nack", sdaOe, 0);
        checkOutput("t2 busy after nack", busy, 0);
        i2cStop();
        i2cStart();
        writeByte(8'h05, ack);
        readByte(d, 1'b1); checkOutput("t2 pointer 6 read", d, 8'hC6);
        i2cStop();

        // Test 3: wrong address is ignored
        oe0 = oeCount;
        busy0 = busyCount;
        i2cStart();
        writeByte(8'h06, ack); checkOutput("t3 addr nack", ack, 1);
        writeByte(8'h77, ack); checkOutput("t3 data nack", ack, 1);
        i2cStop();
        checkOutput("t3 sda_oe cycles", oeCount - oe0, 0);
        checkOutput("t3 busy cycles", busyCount - busy0, 0);
        readReg(4'd7, d); checkOutput("t3 regs[7]", d, 8'h00);
        readReg(4'd4, d); checkOutput("t3 regs[4]", d, 8'hA5);

        // Write table: write a byte, re-point, read it back
        for (int i = 0; i < 4; i++) begin
            ackAny = 1'b0;
            i2cStart();
            writeByte(8'h04, ack); ackAny |= ack;
            writeByte(i2cVec[i].ptrByte, ack); ackAny |= ack;
            writeByte(i2cVec[i].data, ack); ackAny |= ack;
            i2cStart();
            writeByte(8'h04, ack); ackAny |= ack;
            writeByte(i2cVec[i].ptrByte, ack); ackAny |= ack;
            i2cStart();
            writeByte(8'h05, ack); ackAny |= ack;
            readByte(d, 1'b1);
            i2cStop();
            checkOutput($sformatf("wvec %0d acks", i), ackAny, 0);
            checkOutput($sformatf("wvec %0d i2c read", i), d, i2cVec[i].data);
            readReg(i2cVec[i].regAddr, d);
            checkOutput($sformatf("wvec %0d host read", i), d, i2cVec[i].data);
        end

        // Test 4: pointer wrap at DEPTH
        base = rxLog.size();
        i2cStart();
        writeByte(8'h04, ack);
        writeByte(8'h0F, ack);
        writeByte(8'h11, ack);
        writeByte(8'h22, ack); checkOutput("t4 wrap ack", ack, 0);
        i2cStop();
        readReg(4'd15, d); checkOutput("t4 regs[15]", d, 8'h11);
        readReg(4'd0, d);  checkOutput("t4 regs[0]", d, 8'h22);
        if (rxLog.size() >= base + 2) begin
            checkOutput("t4 rx_addr 0", rxLog[base], 15);
            checkOutput("t4 rx_addr 1", rxLog[base + 1], 0);
        end else begin
            checkOutput("t4 rx count", rxLog.size() - base, 2);
        end

        // Test 5: host write collides with I2C commit to the same register
        i2cStart();
        writeByte(8'h04, ack);
        writeByte(8'h05, ack);
        d = 8'h33;
        for (int i = 7; i >= 1; i--) writeBit(d[i]);
        sdaM = d[0]; waitQ(1);
        sclM = 1'b1;
        repeat (2) @(negedge clk);
        hostWe = 1'b1; hostAddr = 4'd5; hostWdata = 8'hFF;
        @(negedge clk);
        hostWe = 1'b0;
        checkOutput("t5 host_rdata", hostRdata, 8'h33);
        repeat (2 * Q - 3) @(negedge clk);
        sclM = 1'b0; waitQ(1);
        readBit(ack); checkOutput("t5 ack", ack, 0);
        i2cStop();
        readReg(4'd5, d); checkOutput("t5 regs[5]", d, 8'h33);

        // Test 6: reset during the 4th data bit of a read (A5 -> bit is 0)
        i2cStart();
        writeByte(8'h04, ack);
        writeByte(8'h04, ack);
        i2cStart();
        writeByte(8'h05, ack);
        readBit(bitv); readBit(bitv); readBit(bitv);
        checkOutput("t6 bit3", bitv, 1);
        sdaM = 1'b1; waitQ(1);
        sclM = 1'b1; waitQ(1);
        checkOutput("t6 driving bit4", sdaOe, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6 sda_oe after reset", sdaOe, 0);
        checkOutput("t6 busy after reset", busy, 0);
        reset = 1'b0;
        sclM = 1'b0; waitQ(1);
        i2cStop();
        readReg(4'd4, d); checkOutput("t6 regs[4] cleared", d, 8'h00);
        i2cStart();
        writeByte(8'h04, ack); checkOutput("t6 addr ack", ack, 0);
        writeByte(8'h02, ack);
        writeByte(8'h9C, ack); checkOutput("t6 data ack", ack, 0);
        i2cStop();
        readReg(4'd2, d); checkOutput("t6 regs[2]", d, 8'h9C);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- Parametrised I2C target with a DEPTH-byte register file; next generation of the SCL-clocked slave.
- Runs on one system clock and oversamples SCL/SDA, so there is no derived SCL clock domain.
- Supports configurable 7-bit address, register-pointer writes, multi-byte burst read/write with auto-increment and wrap, repeated START, and a host-side register port.
- Sits between the board-level open-drain pad (sda_i/sda_oe) and on-chip logic.

Parameters:
- SLAVE_ADDR, 7'h02, 7-bit I2C address this target acknowledges.
- DEPTH, 16, number of byte registers; power of two, 2..256.
- AW, $clog2(DEPTH), register pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; must be >= 16x SCL frequency.
- reset  input  1  synchronous, active-high.
- scl_i  input  1  raw SCL from the pad (asynchronous).
- sda_i  input  1  raw SDA from the pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release. The pad ties the output value to 0.
- host_we  input  1  host write strobe.
- host_addr  input  AW  host register address.
- host_wdata  input  8  host write data.
- host_rdata  output  8  registered read of host_addr; 1-cycle latency.
- rx_valid  output  1  1-cycle pulse when an I2C-written data byte commits to the register file.
- rx_addr  output  AW  register address of that committed byte.
- busy  output  1  high from an address-matched START until STOP or NACK.

Behaviour:
Input conditioning and bus event detection:
- scl_i and sda_i each pass through a 2-FF synchroniser plus one history stage.
- SCL rise/fall are detected from the history stage.
- START: SDA 1->0 while SCL is 1. STOP: SDA 0->1 while SCL is 1.
- SDA is sampled on the SCL-rise cycle. sda_oe changes only on the SCL-fall cycle.

Reset:
- sda_oe=0, busy=0, rx_valid=0, host_rdata=0, state=IDLE, pointer=0, all registers=0.
- Reset asserted mid-transaction releases SDA on the next clk edge.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state (repeated START included): bit counter cleared, go to ADDR.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- ADDR: shift 8 bits MSB first.
  - Bits [7:1]==SLAVE_ADDR: go to ADDR_ACK and drive ACK through the 9th SCL high phase; busy=1.
  - Mismatch: go to IDLE with no ACK.
- After ADDR_ACK:
  - R/W=0: go to PTR.
  - R/W=1: go to RDATA, load the shift register from regs[pointer] at the ACK-clock fall, and drive the MSB.
- PTR: the received byte sets pointer = byte[AW-1:0] (upper bits ignored). ACK, then go to WDATA.
- WDATA: on the 8th bit, write regs[pointer], pulse rx_valid with rx_addr=pointer, pointer += 1 mod DEPTH. ACK, then stay in the WDATA loop.
- RDATA: drive 8 bits; pointer += 1 mod DEPTH after the 8th bit.
- RDATA_ACK: release SDA and sample the master's ACK.
  - ACK (0): load the next byte and return to RDATA.
  - NACK (1): go to IDLE, busy=0; STOP is still honoured.
- Pointer persists across transactions: a write of only a pointer byte, then repeated START + read, reads from that pointer.

Host port and conflicts:
- host_we writes regs[host_addr] in the same cycle.
- An I2C commit and host_we to the same address in the same cycle: the I2C write wins.
- host_rdata reflects regs[host_addr] one cycle later, including same-cycle writes (post-write value).

Glitches:
- SDA changes while SCL is high that are not START/STOP do not occur under the bus protocol.
- If one occurs mid-byte as a START/STOP, the START/STOP rule above applies.

Decomposition:
- Package i2c_pkg:
  - state enum constants;
  - ACK=1'b0, NACK=1'b1;
  - SYNC_STAGES=2.
- Sub-module i2c_bus_cond: synchronisers, edge detect, start/stop detect. Outputs scl_rise, scl_fall, start, stop and sda_s.
- Register file inline in the top. The FSM and shifter live in i2c_slave_regs.

Test Plan:
1. Write 0x04 (pointer), 0xA5, 0x5A to address 0x02 -> three ACKs; regs[4]=0xA5, regs[5]=0x5A; rx_valid pulses with rx_addr 4 then 5; busy low after STOP.
2. Write pointer 0x04, repeated START, read 2 bytes (ACK, NACK) -> SDA returns 0xA5, 0x5A; sda_oe=0 after NACK; pointer=6.
3. Address 0x03 -> no ACK (sda_oe stays 0 for the whole frame); busy=0; regs unchanged.
4. DEPTH=16: pointer 0x0F, write 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap).
5. host_we to addr 5 with 0xFF in the same cycle the I2C commits 0x33 to addr 5 -> regs[5]=0x33; host_rdata=0x33 next cycle.
6. Assert reset during the 4th data bit of a read -> sda_oe=0 next cycle; a subsequent START+ADDR transaction is acknowledged normally.
